// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the gated frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_e;

    localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
    localparam int unsigned CNT_W_DEF       = 20;
    // Largest value a 6-digit decimal display can render.
    localparam int unsigned SAT_MAX_DEF     = 999_999;

endpackage

// File: rtl/freq_meter_if.sv
// Measurement bus of the frequency meter: async input, enable and published result.
interface freq_meter_if #(
    parameter int unsigned CNT_W = 20
);
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] freq_bin;
    logic             freq_valid;
    logic             overflow;

    modport master (
        output sig_in,
        output enable,
        input  freq_bin,
        input  freq_valid,
        input  overflow
    );

    modport slave (
        input  sig_in,
        input  enable,
        output freq_bin,
        output freq_valid,
        output overflow
    );
endinterface

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchronizer followed by a delay register; emits a one-cycle pulse per
// rising edge of an asynchronous input.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);
    logic [1:0] sync_q;
    logic       dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            dly_q  <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~dly_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a window of
// GATE_CYCLES clocks and publishes a saturated count with a one-cycle valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SAT_MAX     = SAT_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    freq_meter_if.slave  bus
);
    localparam int unsigned GC_W = $clog2(GATE_CYCLES);
    localparam logic [GC_W-1:0]  GATE_LAST = GC_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'(SAT_MAX);

    logic rise;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.sig_in),
        .rise_o  (rise)
    );

    state_e            state_q, state_d;
    logic [GC_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  freq_bin_q, freq_bin_d;
    logic              overflow_q, overflow_d;
    logic              valid_q, valid_d;

    logic              at_sat;
    logic [CNT_W-1:0]  closing_cnt;

    assign at_sat = (edge_cnt_q == SAT_VAL);
    // edge_cnt never exceeds SAT_VAL, so adding the terminal-cycle rise cannot wrap.
    assign closing_cnt = at_sat ? SAT_VAL : edge_cnt_q + CNT_W'(rise);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            freq_bin_q <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            freq_bin_q <= freq_bin_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        freq_bin_d = freq_bin_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                ovf_d      = 1'b0;
                if (bus.enable) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (gate_cnt_q == GATE_LAST) begin
                    // The terminal cycle publishes even if enable has just dropped.
                    freq_bin_d = closing_cnt;
                    overflow_d = ovf_q | (rise & at_sat);
                    valid_d    = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = bus.enable ? GATE : IDLE;
                end else if (!bus.enable) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                    if (rise) begin
                        if (at_sat) begin
                            ovf_d = 1'b1;
                        end else begin
                            edge_cnt_d = edge_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.freq_bin   = freq_bin_q;
    assign bus.freq_valid = valid_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a default-saturation instance and a SAT_MAX=40 instance
// share the same stimulus, both with a 100-cycle gate window.
module tb_freq_meter;
    localparam int unsigned GC = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic sig_in;
    int   period = 0;
    logic level = 1'b0;
    int   phase = 0;

    int n_checks = 0;
    int n_fails  = 0;

    freq_meter_if #(.CNT_W(20)) bus_a ();
    freq_meter_if #(.CNT_W(20)) bus_b ();

    assign bus_a.sig_in = sig_in;
    assign bus_a.enable = enable;
    assign bus_b.sig_in = sig_in;
    assign bus_b.enable = enable;

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(20), .SAT_MAX(999_999)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(20), .SAT_MAX(40)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Square-wave source: period==0 holds sig_in at level, otherwise high for period/2 clocks.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (period == 0) begin
                sig_in = level;
            end else begin
                phase  = (phase >= period - 1) ? 0 : phase + 1;
                sig_in = (phase < period / 2);
            end
        end
    end

    // Bounded wait for freq_valid; returns the number of clock edges waited.
    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (bus_a.freq_valid !== 1'b1 && cycles < 400);
        if (bus_a.freq_valid !== 1'b1) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s_timeout: no freq_valid within %0d cycles", tag, cycles);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_a.freq_bin, bus_a.freq_valid, bus_a.overflow} !== 22'd0) begin
            n_fails++;
            $display("FAIL reset_a: bin=%0d valid=%b ovf=%b, required 0/0/0",
                     bus_a.freq_bin, bus_a.freq_valid, bus_a.overflow);
        end
        n_checks++;
        if ({bus_b.freq_bin, bus_b.freq_valid, bus_b.overflow} !== 22'd0) begin
            n_fails++;
            $display("FAIL reset_b: bin=%0d valid=%b ovf=%b, required 0/0/0",
                     bus_b.freq_bin, bus_b.freq_valid, bus_b.overflow);
        end
        #3 rst = 1'b0;
        $display("test_reset: outputs cleared");
    endtask

    task automatic test_period10();
        int cyc;
        period = 10;
        enable = 1'b1;
        wait_valid("p10_first", cyc);
        n_checks++;
        if (bus_a.freq_bin !== 20'd10 || bus_a.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL p10_value: bin=%0d ovf=%b, required 10/0", bus_a.freq_bin, bus_a.overflow);
        end
        wait_valid("p10_second", cyc);
        n_checks++;
        if (cyc != GC) begin
            n_fails++;
            $display("FAIL p10_period: valid spacing=%0d, required %0d", cyc, GC);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_a.freq_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL p10_pulse_width: valid=%b one cycle later, required 0", bus_a.freq_valid);
        end
        $display("test_period10: bin=%0d spacing=%0d", bus_a.freq_bin, cyc);
    endtask

    task automatic test_fast_and_saturation();
        int cyc;
        period = 2;
        wait_valid("fast_mixed", cyc);
        wait_valid("fast", cyc);
        n_checks++;
        if (bus_a.freq_bin !== 20'd50 || bus_a.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL fast_a: bin=%0d ovf=%b, required 50/0", bus_a.freq_bin, bus_a.overflow);
        end
        n_checks++;
        if (bus_b.freq_bin !== 20'd40 || bus_b.overflow !== 1'b1) begin
            n_fails++;
            $display("FAIL sat_b: bin=%0d ovf=%b, required 40/1", bus_b.freq_bin, bus_b.overflow);
        end
        $display("test_fast_and_saturation: a=%0d b=%0d ovf_b=%b", bus_a.freq_bin, bus_b.freq_bin, bus_b.overflow);
        period = 10;
        wait_valid("recover_mixed", cyc);
        wait_valid("recover", cyc);
        n_checks++;
        if (bus_b.freq_bin !== 20'd10 || bus_b.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL sat_recover_b: bin=%0d ovf=%b, required 10/0", bus_b.freq_bin, bus_b.overflow);
        end
        $display("test_sat_recover: b=%0d ovf_b=%b", bus_b.freq_bin, bus_b.overflow);
    endtask

    task automatic test_abort();
        int cyc;
        int seen;
        wait_valid("abort_sync", cyc);
        repeat (50) @(posedge clk);
        #4 enable = 1'b0;
        seen = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (bus_a.freq_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fails++;
            $display("FAIL abort_no_valid: %0d valid pulses while disabled, required 0", seen);
        end
        n_checks++;
        if (bus_a.freq_bin !== 20'd10) begin
            n_fails++;
            $display("FAIL abort_hold: bin=%0d, required 10", bus_a.freq_bin);
        end
        #3 enable = 1'b1;
        wait_valid("reenable", cyc);
        n_checks++;
        if (cyc != GC + 1 || bus_a.freq_bin !== 20'd10) begin
            n_fails++;
            $display("FAIL reenable: latency=%0d bin=%0d, required %0d/10", cyc, bus_a.freq_bin, GC + 1);
        end
        $display("test_abort: latency=%0d bin=%0d", cyc, bus_a.freq_bin);
    endtask

    task automatic test_reset_mid();
        int cyc;
        wait_valid("rstmid_sync", cyc);
        repeat (30) @(posedge clk);
        #4 rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_a.freq_bin !== 20'd0 || bus_a.overflow !== 1'b0 || bus_a.freq_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_mid: bin=%0d ovf=%b valid=%b, required 0/0/0",
                     bus_a.freq_bin, bus_a.overflow, bus_a.freq_valid);
        end
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        wait_valid("rst_release", cyc);
        n_checks++;
        if (bus_a.freq_bin !== 20'd10 || cyc != GC + 1) begin
            n_fails++;
            $display("FAIL rst_release: bin=%0d latency=%0d, required 10/%0d", bus_a.freq_bin, cyc, GC + 1);
        end
        $display("test_reset_mid: bin=%0d latency=%0d", bus_a.freq_bin, cyc);
    endtask

    task automatic test_constant_and_terminal();
        int cyc;
        period = 0;
        level  = 1'b1;
        wait_valid("const1_mixed", cyc);
        wait_valid("const1", cyc);
        n_checks++;
        if (bus_a.freq_bin !== 20'd0) begin
            n_fails++;
            $display("FAIL const_high: bin=%0d, required 0", bus_a.freq_bin);
        end
        level = 1'b0;
        wait_valid("const0_mixed", cyc);
        wait_valid("const0", cyc);
        n_checks++;
        if (bus_a.freq_bin !== 20'd0) begin
            n_fails++;
            $display("FAIL const_low: bin=%0d, required 0", bus_a.freq_bin);
        end
        // sig_in rises 97 edges after the strobe, so rise is high on the terminal cycle.
        repeat (96) @(posedge clk);
        #4 level = 1'b1;
        wait_valid("terminal", cyc);
        n_checks++;
        if (bus_a.freq_bin !== 20'd1) begin
            n_fails++;
            $display("FAIL terminal_rise: bin=%0d, required 1", bus_a.freq_bin);
        end
        wait_valid("after_terminal", cyc);
        n_checks++;
        if (bus_a.freq_bin !== 20'd0) begin
            n_fails++;
            $display("FAIL after_terminal: bin=%0d, required 0", bus_a.freq_bin);
        end
        $display("test_constant_and_terminal: bin=%0d", bus_a.freq_bin);
    endtask

    initial begin
        test_reset();
        test_period10();
        test_fast_and_saturation();
        test_abort();
        test_reset_mid();
        test_constant_and_terminal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
